smol_lsu: RTL and testbench
===========================

# smol_lsu

Load/store unit for smolCore, sitting directly downstream of the ALU in the execute stage. It takes the ALU result as the effective address, together with store data and the instruction's funct3, and runs one data-memory transaction over a req/gnt/rvalid bus. Load data is aligned and sign- or zero-extended before it is returned to register-file writeback. Misaligned accesses and illegal funct3 values raise a fault and never reach memory.

## Interface
- No parameters. XLEN is fixed at 32.
- clk  in  1  core clock; all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- req_valid  in  1  execute stage presents a memory op
- req_ready  out  1  high only in IDLE; op accepted when req_valid && req_ready
- req_is_store  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I encoding:
  - loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
  - stores: 000 SB, 001 SH, 010 SW
- req_addr  in  32  effective address (ALU alu_out)
- req_wdata  in  32  store data (rs2)
- req_rd  in  5  load destination register
- mem_req  out  1  bus request, held until granted
- mem_we  out  1  write enable
- mem_addr  out  32  word address, {req_addr[31:2], 2'b00}
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-replicated store data
- mem_gnt  in  1  request accepted this cycle
- mem_rvalid  in  1  read data valid; earliest the cycle after gnt
- mem_rdata  in  32  read word
- wb_valid  out  1  one-cycle pulse, load result valid
- wb_rd  out  5  destination register
- wb_data  out  32  extended load result
- op_done  out  1  one-cycle pulse when any op retires (load, store or fault)
- fault  out  1  one-cycle pulse, misaligned or illegal op; coincides with op_done

## Operation
- FSM states:
  - IDLE: req_ready=1.
    - On accept of a legal op: latch address, funct3, rd and store flag; compute lanes; go to REQ.
    - On accept of an illegal op: go to FAULT.
  - REQ: mem_req=1, with mem_we/addr/be/wdata stable from the latch.
    - On mem_gnt with a store: go to DONE.
    - On mem_gnt with a load: go to WAIT.
  - WAIT: on mem_rvalid, capture the extended data and go to DONE.
  - DONE: op_done=1; wb_valid=1 if the op is a load; go to IDLE.
  - FAULT: op_done=1 and fault=1; no bus activity; go to IDLE.
- Illegal op, checked at accept:
  - halfword with addr[0]=1
  - word with addr[1:0]≠0
  - load funct3 ∈ {011, 110, 111}
  - store funct3 ∉ {000, 001, 010}
- Store lanes:
  - SB: be = 4'b0001 << addr[1:0]; wdata = {4{wdata[7:0]}}
  - SH: be = 4'b0011 << {addr[1],1'b0}; wdata = {2{wdata[15:0]}}
  - SW: be = 4'b1111; wdata = wdata
- Load extract:
  - byte = mem_rdata >> (8*addr[1:0]); half = mem_rdata >> (16*addr[1])
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
  - Loads drive be as for the matching store width.
- wb_rd=0 is still reported with wb_valid; the register file ignores x0.
- mem_rvalid outside WAIT and mem_gnt outside REQ are ignored.

## Timing
- Reset values, after the first rst_n=0 edge:
  - state IDLE, req_ready=1
  - mem_req=0, mem_we=0, mem_be=0
  - wb_valid=0, op_done=0, fault=0
  - mem_addr, mem_wdata, wb_rd, wb_data = 0
- Reset mid-operation abandons the transaction. mem_req drops at the reset edge, and no op_done or wb_valid pulse follows.
- Accept at cycle T → mem_req from T+1.
- Store with gnt at T+1 → op_done at T+2, req_ready at T+2.
- Load with gnt at T+1 and rvalid at T+2 → wb_valid/op_done at T+3.
- Fault accepted at T → fault/op_done at T+1, req_ready at T+1.
- Gnt stall: REQ is held indefinitely with all mem_* outputs stable.
- rvalid stall: WAIT is held indefinitely.
- Upstream holds req_* while req_ready=0. Inputs are sampled only on accept.
- Throughput: at most one op in flight; no pipelining.

## Structure
- smol_pkg holds:
  - lsu_state_e {IDLE, REQ, WAIT, DONE, FAULT}
  - funct3 localparams: F3_B, F3_H, F3_W, F3_BU, F3_HU
- Sub-module smol_lsu_align, purely combinational:
  - inputs: funct3, addr[1:0], wdata, rdata
  - outputs: be, lane wdata, extended rdata, misaligned/illegal flag
  - smol_lsu instantiates it once and holds only the FSM and latches.

## Test plan
- SB, addr 0x1003, wdata 0xAABBCCDD, gnt immediate → mem_addr 0x1000, be 4'b1000, wdata 0xDDDDDDDD, we=1; op_done at T+2; no wb_valid.
- LB, addr 0x2001, rdata 0x0000_8000, rd 5 → wb_data 0xFFFFFF80, wb_rd 5, wb_valid at T+3. LBU, same address and data → 0x00000080.
- LH, addr 0x3002, rdata 0x7FFF_1234 → wb_data 0x00007FFF. SH at the same address → be 4'b1100.
- LW, addr 0x4001 → fault and op_done at T+1; mem_req never asserted. Load funct3 3'b111 → same response.
- LW, gnt delayed 5 cycles, then rvalid delayed 3 cycles → mem_* stable throughout, req_ready=0, single wb_valid pulse. A spurious rvalid while in REQ is ignored.
- rst_n=0 while in WAIT → next cycle state IDLE, req_ready=1, mem_req=0; a later rvalid produces no wb_valid.

Source files
------------

// File: rtl/smol_pkg.sv
// ============================================================================
// smol_pkg : shared types and funct3 encodings for the smolCore load/store unit
// Revision : 1.0
// ============================================================================
`default_nettype none

package smol_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    DONE  = 3'd3,
    FAULT = 3'd4
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

endpackage

`default_nettype wire

// File: rtl/smol_lsu_align.sv
// ============================================================================
// smol_lsu_align : byte-lane steering, load extension and legality check
// Revision       : 1.0
// ============================================================================
`default_nettype none

module smol_lsu_align
  import smol_pkg::*;
(
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] lane_wdata,
  output logic [31:0] rdata_ext,
  output logic        illegal
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = 8'(rdata >> {addr_lo, 3'b000});
  assign half_sel = 16'(rdata >> {addr_lo[1], 4'b0000});

  always_comb begin
    be         = 4'b0000;
    lane_wdata = 32'h0;
    illegal    = 1'b0;
    rdata_ext  = 32'h0;

    case (funct3[1:0])
      2'b00: begin
        be         = 4'b0001 << addr_lo;
        lane_wdata = {4{wdata[7:0]}};
      end
      2'b01: begin
        be         = 4'b0011 << {addr_lo[1], 1'b0};
        lane_wdata = {2{wdata[15:0]}};
        illegal    = addr_lo[0];
      end
      2'b10: begin
        be         = 4'b1111;
        lane_wdata = wdata;
        illegal    = (addr_lo != 2'b00);
      end
      default: illegal = 1'b1;
    endcase

    // Stores have no unsigned forms; loads have no 110/111 encodings.
    if (funct3[2] && (is_store || funct3[1])) begin
      illegal = 1'b1;
    end

    case (funct3)
      F3_B:    rdata_ext = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    rdata_ext = {{16{half_sel[15]}}, half_sel};
      F3_W:    rdata_ext = rdata;
      F3_BU:   rdata_ext = {24'h0, byte_sel};
      F3_HU:   rdata_ext = {16'h0, half_sel};
      default: rdata_ext = 32'h0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/smol_lsu.sv
// ============================================================================
// smol_lsu : single-outstanding load/store unit on a req/gnt/rvalid bus
// Revision : 1.0
// ============================================================================
`default_nettype none

module smol_lsu
  import smol_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        op_done,
  output logic        fault
);

  lsu_state_e  state_q, state_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  addr_lo_q, addr_lo_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic [31:0] wb_data_q, wb_data_d;

  logic        is_idle;
  logic        al_store;
  logic [2:0]  al_f3;
  logic [1:0]  al_addr_lo;
  logic [3:0]  al_be;
  logic [31:0] al_wdata;
  logic [31:0] al_rdata_ext;
  logic        al_illegal;

  // The aligner sees the live request while idle and the latched op afterwards,
  // so one instance serves both the accept check and the load extraction.
  assign is_idle    = (state_q == IDLE);
  assign al_store   = is_idle ? req_is_store    : mem_we_q;
  assign al_f3      = is_idle ? req_funct3      : f3_q;
  assign al_addr_lo = is_idle ? req_addr[1:0]   : addr_lo_q;

  smol_lsu_align u_align (
    .is_store   (al_store),
    .funct3     (al_f3),
    .addr_lo    (al_addr_lo),
    .wdata      (req_wdata),
    .rdata      (mem_rdata),
    .be         (al_be),
    .lane_wdata (al_wdata),
    .rdata_ext  (al_rdata_ext),
    .illegal    (al_illegal)
  );

  always_comb begin
    state_d     = state_q;
    f3_d        = f3_q;
    addr_lo_d   = addr_lo_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    wb_rd_d     = wb_rd_q;
    wb_data_d   = wb_data_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (al_illegal) begin
            state_d = FAULT;
          end else begin
            state_d     = REQ;
            f3_d        = req_funct3;
            addr_lo_d   = req_addr[1:0];
            mem_we_d    = req_is_store;
            mem_addr_d  = {req_addr[31:2], 2'b00};
            mem_be_d    = al_be;
            mem_wdata_d = al_wdata;
            wb_rd_d     = req_rd;
          end
        end
      end
      REQ: begin
        if (mem_gnt) begin
          state_d = mem_we_q ? DONE : WAIT;
        end
      end
      WAIT: begin
        if (mem_rvalid) begin
          wb_data_d = al_rdata_ext;
          state_d   = DONE;
        end
      end
      DONE:    state_d = IDLE;
      FAULT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      f3_q        <= 3'b000;
      addr_lo_q   <= 2'b00;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_be_q    <= 4'b0000;
      mem_wdata_q <= 32'h0;
      wb_rd_q     <= 5'd0;
      wb_data_q   <= 32'h0;
    end else begin
      state_q     <= state_d;
      f3_q        <= f3_d;
      addr_lo_q   <= addr_lo_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      wb_rd_q     <= wb_rd_d;
      wb_data_q   <= wb_data_d;
    end
  end

  assign req_ready = is_idle;
  assign mem_req   = (state_q == REQ);
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_be    = mem_be_q;
  assign mem_wdata = mem_wdata_q;
  assign wb_valid  = (state_q == DONE) && !mem_we_q;
  assign wb_rd     = wb_rd_q;
  assign wb_data   = wb_data_q;
  assign op_done   = (state_q == DONE) || (state_q == FAULT);
  assign fault     = (state_q == FAULT);

endmodule

`default_nettype wire

// File: tb/tb_smol_lsu.sv
// ============================================================================
// tb_smol_lsu : randomized and directed checks of smol_lsu against an op-level model
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_smol_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic [4:0]  req_rd;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        wb_valid, op_done, fault;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  smol_lsu dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .op_done(op_done), .fault(fault)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Expected outputs for the current cycle, set by the stimulus after each edge.
  logic        chk_en = 1'b0;
  logic        e_rst, e_ready, e_mem_req, e_we, e_wb_valid, e_op_done, e_fault;
  logic [31:0] e_addr, e_wdata, e_wb_data;
  logic [3:0]  e_be;
  logic [4:0]  e_wb_rd;

  logic [31:0] cap_addr, cap_wdata, cap_wb_data;
  logic [3:0]  cap_be;
  logic [4:0]  cap_wb_rd;
  logic        cap_we;
  logic        saw_mem_req;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("req_ready", 32'(req_ready), 32'(e_ready));
      chk("mem_req",   32'(mem_req),   32'(e_mem_req));
      chk("op_done",   32'(op_done),   32'(e_op_done));
      chk("wb_valid",  32'(wb_valid),  32'(e_wb_valid));
      chk("fault",     32'(fault),     32'(e_fault));
      if (mem_req) saw_mem_req = 1'b1;
      if (e_mem_req) begin
        chk("mem_addr",  mem_addr,        e_addr);
        chk("mem_be",    32'(mem_be),     32'(e_be));
        chk("mem_wdata", mem_wdata,       e_wdata);
        chk("mem_we",    32'(mem_we),     32'(e_we));
        cap_addr = mem_addr; cap_be = mem_be; cap_wdata = mem_wdata; cap_we = mem_we;
      end
      if (e_wb_valid) begin
        chk("wb_rd",   32'(wb_rd), 32'(e_wb_rd));
        chk("wb_data", wb_data,    e_wb_data);
        cap_wb_rd = wb_rd; cap_wb_data = wb_data;
      end
      if (e_rst) begin
        chk("rst_mem_addr",  mem_addr,      32'h0);
        chk("rst_mem_wdata", mem_wdata,     32'h0);
        chk("rst_mem_we",    32'(mem_we),   32'h0);
        chk("rst_mem_be",    32'(mem_be),   32'h0);
        chk("rst_wb_rd",     32'(wb_rd),    32'h0);
        chk("rst_wb_data",   wb_data,       32'h0);
      end
    end
  end

  // Op-level model: access size from funct3, lanes by byte offset, extension by masking.
  task automatic model(input bit st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] rdata,
                       output bit ill, output logic [3:0] be,
                       output logic [31:0] lw, output logic [31:0] ext);
    int size, off;
    bit sgn;
    logic [31:0] mask, v;
    off = int'(a[1:0]);
    size = 0; sgn = 1'b0;
    if (st) begin
      if (f3 == 3'd0) size = 1; else if (f3 == 3'd1) size = 2; else if (f3 == 3'd2) size = 4;
    end else begin
      case (f3)
        3'd0: begin size = 1; sgn = 1'b1; end
        3'd1: begin size = 2; sgn = 1'b1; end
        3'd2: size = 4;
        3'd4: size = 1;
        3'd5: size = 2;
        default: size = 0;
      endcase
    end
    ill = (size == 0) || (off % size != 0);
    be = '0; lw = '0; ext = '0;
    if (!ill) begin
      be = 4'(((1 << size) - 1) << off);
      if (size == 1)      lw = {24'h0, wd[7:0]} * 32'h0101_0101;
      else if (size == 2) lw = {16'h0, wd[15:0]} * 32'h0001_0001;
      else                lw = wd;
      mask = (size == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * size)) - 32'h1);
      v = (rdata >> (8 * off)) & mask;
      if (sgn && ((v & ~(mask >> 1)) != 0)) v = v | ~mask;
      ext = v;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_idle();
    e_rst = 1'b0; e_ready = 1'b1; e_mem_req = 1'b0; e_we = 1'b0;
    e_wb_valid = 1'b0; e_op_done = 1'b0; e_fault = 1'b0;
  endtask

  task automatic exp_busy();
    exp_idle();
    e_ready = 1'b0;
  endtask

  task automatic do_op(input bit st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [4:0] rd,
                       input int gd, input int rvd, input logic [31:0] rdata);
    bit ill;
    logic [3:0] be;
    logic [31:0] lw, ext;
    model(st, f3, a, wd, rdata, ill, be, lw, ext);
    saw_mem_req = 1'b0;
    // accept cycle
    step();
    req_valid = 1'b1; req_is_store = st; req_funct3 = f3; req_addr = a;
    req_wdata = wd; req_rd = rd; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    exp_idle();
    if (ill) begin
      step();
      req_valid = 1'b0;
      exp_busy(); e_op_done = 1'b1; e_fault = 1'b1;
      return;
    end
    for (int i = 0; i <= gd; i++) begin
      step();
      req_valid = 1'b0;
      mem_gnt = (i == gd);
      mem_rvalid = (i < gd) ? 1'($urandom_range(0, 1)) : 1'b0;
      mem_rdata = $urandom;
      exp_busy(); e_mem_req = 1'b1; e_addr = {a[31:2], 2'b00}; e_be = be;
      e_wdata = lw; e_we = st;
    end
    if (!st) begin
      for (int j = 0; j <= rvd; j++) begin
        step();
        mem_gnt = 1'($urandom_range(0, 1));
        mem_rvalid = (j == rvd);
        mem_rdata = (j == rvd) ? rdata : $urandom;
        exp_busy();
      end
    end
    step();
    mem_gnt = 1'b0; mem_rvalid = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
    exp_busy(); e_op_done = 1'b1; e_wb_valid = !st; e_wb_rd = rd; e_wb_data = ext;
  endtask

  task automatic settle();
    step();
    req_valid = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    exp_idle();
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_is_store = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'h0; req_wdata = 32'h0; req_rd = 5'd0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    exp_idle();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_idle(); e_rst = 1'b1; chk_en = 1'b1;

    // SB lane replication and byte enable on the top lane
    do_op(1'b1, 3'b000, 32'h0000_1003, 32'hAABB_CCDD, 5'd0, 0, 0, 32'h0);
    settle();
    chk("sb_addr", cap_addr, 32'h0000_1000);
    chk("sb_be", 32'(cap_be), 32'h8);
    chk("sb_wdata", cap_wdata, 32'hDDDD_DDDD);
    chk("sb_we", 32'(cap_we), 32'h1);

    do_op(1'b0, 3'b000, 32'h0000_2001, 32'h0, 5'd5, 0, 0, 32'h0000_8000);
    settle();
    chk("lb_data", cap_wb_data, 32'hFFFF_FF80);
    chk("lb_rd", 32'(cap_wb_rd), 32'd5);

    do_op(1'b0, 3'b100, 32'h0000_2001, 32'h0, 5'd5, 0, 0, 32'h0000_8000);
    settle();
    chk("lbu_data", cap_wb_data, 32'h0000_0080);

    do_op(1'b0, 3'b001, 32'h0000_3002, 32'h0, 5'd7, 0, 0, 32'h7FFF_1234);
    settle();
    chk("lh_data", cap_wb_data, 32'h0000_7FFF);

    do_op(1'b1, 3'b001, 32'h0000_3002, 32'h1234_5678, 5'd0, 0, 0, 32'h0);
    settle();
    chk("sh_be", 32'(cap_be), 32'hC);

    do_op(1'b0, 3'b010, 32'h0000_4001, 32'h0, 5'd3, 0, 0, 32'h0);
    settle();
    chk("lw_mis_no_req", 32'(saw_mem_req), 32'h0);
    do_op(1'b0, 3'b111, 32'h0000_4000, 32'h0, 5'd3, 0, 0, 32'h0);
    settle();
    chk("f3_111_no_req", 32'(saw_mem_req), 32'h0);

    // long grant and read-valid stalls
    do_op(1'b0, 3'b010, 32'h0000_5008, 32'h0, 5'd9, 5, 3, 32'hCAFE_F00D);
    settle();
    chk("lw_stall_data", cap_wb_data, 32'hCAFE_F00D);

    // reset while waiting for read data abandons the load
    step();
    req_valid = 1'b1; req_is_store = 1'b0; req_funct3 = 3'b010;
    req_addr = 32'h0000_6000; req_rd = 5'd4; exp_idle();
    step();
    req_valid = 1'b0; mem_gnt = 1'b1;
    exp_busy(); e_mem_req = 1'b1; e_addr = 32'h0000_6000; e_be = 4'hF;
    e_wdata = req_wdata; e_we = 1'b0;
    step();
    mem_gnt = 1'b0; exp_busy();
    step();
    rst_n = 1'b0; exp_busy();
    step();
    rst_n = 1'b1; exp_idle(); e_rst = 1'b1;
    step();
    mem_rvalid = 1'b1; mem_rdata = 32'h1111_2222; exp_idle();
    step();
    mem_rvalid = 1'b0; exp_idle();

    for (int n = 0; n < 200; n++) begin
      logic [31:0] a;
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      do_op(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom,
            5'($urandom_range(0, 31)), $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
      if ($urandom_range(0, 2) == 0) begin
        step();
        req_valid = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0; exp_idle();
      end
    end
    settle();
    chk_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
